impix_system_pio_ext: RTL
=========================

Name: impix_system_pio_ext

Overview:
Parametrised general-purpose I/O peripheral on an Avalon-MM slave port, and the successor to the fixed 8-bit PIO in impix_system.
- Channel width is configurable.
- Input synchronizer depth is configurable.
- Per-channel digital debounce is available.
- Edge sensitivity (rising, falling or any edge) is selected per channel at runtime.
- Output set/clear registers are supported, and the output register can be read back.
- A single level interrupt goes to the Nios II IRQ line.

Parameters:
DATA_WIDTH, 8, number of I/O channels (1..32); readdata is zero-extended above this width.
SYNC_STAGES, 2, flip-flops in the in_port synchronizer chain (2..4).
DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a debounced input changes; 0 bypasses the debounce counters.

Ports:
clk  in  1  single system clock; all logic is clocked on its rising edge.
reset_n  in  1  asynchronous active-low reset; it is asserted asynchronously and released synchronously by the system.
address  in  3  word address of the register.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
writedata  in  32  write data; only bits [DATA_WIDTH-1:0] are used.
readdata  out  32  registered read data, available 1 cycle after the address is presented.
in_port  in  DATA_WIDTH  asynchronous inputs.
out_port  out  DATA_WIDTH  output register.
irq  out  1  interrupt request, active high, level.

Behaviour:
- Reset values (reset_n=0, asynchronous): every register below is 0, except rise_en and fall_en, which reset to all ones (any-edge mode, backward compatible).
  - Registers cleared to 0: readdata, out_port/data_out, irq_mask, edge_capture, synchronizer stages, debounced value, edge delay register, debounce counters.
  - irq is therefore 0 during reset.
- Register map (R = read, W = write):
  - 0: R returns deb_in; W sets data_out = writedata.
  - 1: R returns data_out; W is ignored.
  - 2: irq_mask, R/W.
  - 3: edge_capture. R returns the captured bits; a W writes 1 to clear the corresponding bit.
  - 4: W performs data_out |= writedata; R returns 0.
  - 5: W performs data_out &= ~writedata; R returns 0.
  - 6: rise_en, R/W.
  - 7: fall_en, R/W.
- Read path:
  - readdata is updated every clock with the mux output for the current address, zero-extended.
  - There are no read side effects; reading edge_capture does not clear it.
- Synchronizer: in_port passes through SYNC_STAGES flip-flops to produce syn_in.
- Debounce, per channel, when DEBOUNCE_CYCLES>0:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If syn_in==deb_in, the counter is cleared.
  - Otherwise the counter increments. On the cycle where the counter equals DEBOUNCE_CYCLES-1 and syn_in still differs from deb_in, deb_in takes syn_in and the counter clears.
  - Any return to equality before that point discards the pending change. A pulse shorter than DEBOUNCE_CYCLES cycles never reaches deb_in.
- Debounce bypass (DEBOUNCE_CYCLES=0): deb_in = syn_in combinationally.
- Edge detection:
  - deb_d is deb_in delayed by one register stage.
  - rise = deb_in & ~deb_d & rise_en.
  - fall = ~deb_in & deb_d & fall_en.
  - edge_capture[i] is set on the next clock when rise[i]|fall[i].
- Latency: from in_port changing (sampled at clock k=1) to edge_capture visible, the delay is SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks. Reading that bit adds 1 further cycle through readdata.
- Simultaneous event and clear: if a write-1-to-clear and a new edge hit the same bit in the same cycle, the set wins and the bit stays 1, so no event is lost. Bits written with 0 are unaffected.
- Changing rise_en/fall_en never sets or clears edge_capture; it only gates future edges.
- irq = |(edge_capture & irq_mask), combinational from registers with no extra latency. irq deasserts in the same cycle that the last unmasked bit clears.
- out_port = data_out, with no added latency; it reflects a write after one clock.
- Writes at addresses 1 and to bits above DATA_WIDTH are ignored.
- Reset asserted mid-debounce or mid-capture clears all pending state immediately. After release, a channel whose input is held high produces a rising edge (deb_in goes 0→1), which is captured if rise_en.

Test Plan:
- Reset with DATA_WIDTH=8: release reset, then read addresses 0..7 → 0x00, 0x00, 0x00, 0x00, 0x00, 0x00, 0xFF, 0xFF; irq=0; out_port=0x00.
- Output set/clear: write 0xA5 to addr 0, 0x0F to addr 4, 0x81 to addr 5 → out_port reads 0xA5, then 0xAF, then 0x2E; reading addr 1 returns 0x2E.
- Edge latency and mode (SYNC_STAGES=2, DEBOUNCE_CYCLES=0):
  - Setup: rise_en=0x00, fall_en=0x01, irq_mask=0x01.
  - Drive in_port[0] 0→1: edge_capture stays 0x00.
  - Drive in_port[0] 1→0: edge_capture[0]=1 exactly 3 clocks later, and irq rises in that same cycle.
  - Write 0x01 to addr 3: irq=0 the next cycle.
- Debounce (DEBOUNCE_CYCLES=4):
  - A 3-cycle high pulse on in_port[2] → addr 0 stays 0x00 and edge_capture stays 0x00.
  - A held high on in_port[2] → deb_in[2]=1 at clock 2+4, and edge_capture=0x04 at clock 7.
- Clear/set collision: align a write of 0x02 to addr 3 with a new edge on channel 1 → edge_capture[1] remains 1.
- DATA_WIDTH=32: drive in_port=0xFFFF_0000 and write 0xFFFF_FFFF to addr 6 and addr 7 → edge_capture=0xFFFF_0000 after 3 clocks; readdata is the full 32 bits with no truncation.

Source files
------------

// File: rtl/impix_system_pio_ext_if.sv
// Avalon-MM slave bus for the PIO: word address, select, active-low write,
// 32-bit data in both directions.
interface impix_system_pio_ext_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/impix_system_pio_ext.sv
// Parametrised GPIO: input synchronizer, optional per-channel debounce,
// per-channel rise/fall edge capture, set/clear output register, level irq.

// One debounce lane: deb follows syn only after it has differed for CYCLES
// consecutive clocks; any return to equality drops the pending change.
module impix_system_pio_ext_deb #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic syn,
  output logic deb
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;

  // stability counter and debounced output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (syn == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      deb <= syn;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module impix_system_pio_ext #(
  parameter int DATA_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  impix_system_pio_ext_if.slave bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] syn_in, deb_in, deb_d;
  logic [DATA_WIDTH-1:0] data_out, irq_mask, edge_capture, rise_en, fall_en;
  logic [DATA_WIDTH-1:0] wdat, rise, fall, clr;
  logic [31:0]           rmux;
  logic                  wr;
  logic                  unused_wr_hi;

  assign wr           = bus.chipselect && !bus.write_n;
  assign wdat         = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wr_hi = ^bus.writedata;

  // in_port synchronizer chain; last stage is the metastability-safe copy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end
  assign syn_in = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign deb_in = syn_in;
    end else begin : g_deb
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
        impix_system_pio_ext_deb #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
          .clk     (clk),
          .reset_n (reset_n),
          .syn     (syn_in[i]),
          .deb     (deb_in[i])
        );
      end
    end
  endgenerate

  assign rise = deb_in & ~deb_d & rise_en;
  assign fall = ~deb_in & deb_d & fall_en;
  // a clear and a new edge on the same bit in one cycle keeps the bit set
  assign clr  = (wr && bus.address == 3'd3) ? wdat : '0;

  // edge delay register and edge capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d        <= '0;
      edge_capture <= '0;
    end else begin
      deb_d        <= deb_in;
      edge_capture <= (edge_capture & ~clr) | rise | fall;
    end
  end

  // writable control registers; edge enables reset to any-edge mode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      irq_mask <= '0;
      rise_en  <= '1;
      fall_en  <= '1;
    end else if (wr) begin
      case (bus.address)
        3'd0:    data_out <= wdat;
        3'd2:    irq_mask <= wdat;
        3'd4:    data_out <= data_out | wdat;
        3'd5:    data_out <= data_out & ~wdat;
        3'd6:    rise_en  <= wdat;
        3'd7:    fall_en  <= wdat;
        default: ;
      endcase
    end
  end

  // read mux, zero-extended to the bus width; reads have no side effects
  always_comb begin
    rmux = '0;
    case (bus.address)
      3'd0:    rmux[DATA_WIDTH-1:0] = deb_in;
      3'd1:    rmux[DATA_WIDTH-1:0] = data_out;
      3'd2:    rmux[DATA_WIDTH-1:0] = irq_mask;
      3'd3:    rmux[DATA_WIDTH-1:0] = edge_capture;
      3'd6:    rmux[DATA_WIDTH-1:0] = rise_en;
      3'd7:    rmux[DATA_WIDTH-1:0] = fall_en;
      default: rmux = '0;
    endcase
  end

  // registered read data, refreshed every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rmux;
  end

  assign out_port = data_out;
  assign irq      = |(edge_capture & irq_mask);
endmodule
